// File: rtl/keypad_sum_controller_pkg.sv
// Shared definitions for the keypad sum controller: key codes, the
// phase enumeration and the display width.
package keypad_sum_pkg;

    // Width of the value accepted by the 4-digit display multiplexer (0..9999).
    localparam int DISP_W = 14;

    // Non-digit key codes produced by the keypad scanner.
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_EQ  = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;

    // Encoding is visible on the phase output, so values are fixed.
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        SHOW    = 2'd2
    } sum_phase_t;

    // Codes 0..9 are decimal digits.
    function automatic logic is_digit_key(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_sum_controller_if.sv
// Key input / display output bundle between the keypad scanner, the sum
// controller and the display multiplexer. The master side drives keys and
// observes the result; the slave side is the controller.
interface keypad_sum_if #(
    parameter int DATA_W = keypad_sum_pkg::DISP_W
);
    logic              key_valid;
    logic [3:0]        key_code;
    logic [DATA_W-1:0] sum_result;
    logic              result_valid;
    logic [1:0]        phase;

    modport master (
        output key_valid,
        output key_code,
        input  sum_result,
        input  result_valid,
        input  phase
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output sum_result,
        output result_valid,
        output phase
    );
endinterface

// File: rtl/keypad_sum_controller_decimal_operand_reg.sv
// One decimal operand: binary value register plus a count of digits typed.
// A digit is accepted only while fewer than MAX_DIGITS have been entered.
// clear together with load_digit starts a fresh operand with that digit.
// value_next is the value the register takes on the coming edge; when no
// control is active it equals the stored value.
module decimal_operand_reg
    import keypad_sum_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int DATA_W     = DISP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load_digit,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value_next
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [DATA_W-1:0] value_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    // Next operand value: restart, clear, or shift in one decimal digit.
    always_comb begin
        value_next = value_reg;
        count_next = count_reg;
        if (clear && load_digit) begin
            value_next = DATA_W'(digit);
            count_next = CNT_W'(1);
        end else if (clear) begin
            value_next = '0;
            count_next = '0;
        end else if (load_digit && (count_reg < CNT_W'(MAX_DIGITS))) begin
            value_next = (value_reg * DATA_W'(10)) + DATA_W'(digit);
            count_next = count_reg + CNT_W'(1);
        end
    end

    // Operand and digit-count storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= '0;
            count_reg <= '0;
        end else begin
            value_reg <= value_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/keypad_sum_controller.sv
// Keypad sum controller: collects two decimal operands from single-cycle key
// pulses, adds them on '=', and drives the display value.
// Optional build macro KEYPAD_ENTRY_ECHO_EN: when defined the display echoes
// the operand being typed; otherwise it only shows the last sum (0 after
// reset/clear). Phase and result_valid behave identically in both builds.
// MAX_DIGITS must be 1..3 so the largest sum fits four display digits.
module keypad_sum_controller
    import keypad_sum_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int DATA_W     = DISP_W
) (
    input  logic         clk,
    input  logic         reset,
    keypad_sum_if.slave  bus
);

    sum_phase_t        state_reg;
    sum_phase_t        state_next;
    logic [DATA_W-1:0] result_reg;
    logic [DATA_W-1:0] result_next;
    logic [DATA_W-1:0] sum_result_reg;
    logic [DATA_W-1:0] disp_next;
    logic              result_valid_reg;

    logic              clr_a;
    logic              load_a;
    logic              clr_b;
    logic              load_b;
    logic              clr_all;
    logic              do_sum;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    decimal_operand_reg #(
        .MAX_DIGITS (MAX_DIGITS),
        .DATA_W     (DATA_W)
    ) u_op_a (
        .clk        (clk),
        .reset      (reset),
        .clear      (clr_a),
        .load_digit (load_a),
        .digit      (bus.key_code),
        .value_next (a_next)
    );

    decimal_operand_reg #(
        .MAX_DIGITS (MAX_DIGITS),
        .DATA_W     (DATA_W)
    ) u_op_b (
        .clk        (clk),
        .reset      (reset),
        .clear      (clr_b),
        .load_digit (load_b),
        .digit      (bus.key_code),
        .value_next (b_next)
    );

    // Key decode: operand controls and next phase for the current key.
    always_comb begin
        state_next = state_reg;
        clr_a      = 1'b0;
        load_a     = 1'b0;
        clr_b      = 1'b0;
        load_b     = 1'b0;
        clr_all    = 1'b0;
        do_sum     = 1'b0;
        if (bus.key_valid) begin
            if (bus.key_code == KEY_CLR) begin
                clr_a      = 1'b1;
                clr_b      = 1'b1;
                clr_all    = 1'b1;
                state_next = ENTER_A;
            end else begin
                unique case (state_reg)
                    ENTER_A: begin
                        if (is_digit_key(bus.key_code)) begin
                            load_a = 1'b1;
                        end else if (bus.key_code == KEY_ADD) begin
                            clr_b      = 1'b1;
                            state_next = ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit_key(bus.key_code)) begin
                            load_b = 1'b1;
                        end else if (bus.key_code == KEY_EQ) begin
                            do_sum     = 1'b1;
                            state_next = SHOW;
                        end
                    end
                    SHOW: begin
                        // A digit here begins a new calculation with that digit.
                        if (is_digit_key(bus.key_code)) begin
                            clr_a      = 1'b1;
                            load_a     = 1'b1;
                            clr_b      = 1'b1;
                            state_next = ENTER_A;
                        end
                    end
                    default: state_next = ENTER_A;
                endcase
            end
        end
    end

    // Adder. On '=' neither operand is being loaded, so the next values
    // equal the stored operands.
    always_comb begin
        result_next = result_reg;
        if (clr_all) begin
            result_next = '0;
        end else if (do_sum) begin
            result_next = a_next + b_next;
        end
    end

    // Display source for the coming cycle.
`ifdef KEYPAD_ENTRY_ECHO_EN
    always_comb begin
        unique case (state_next)
            ENTER_A: disp_next = a_next;
            ENTER_B: disp_next = b_next;
            default: disp_next = result_next;
        endcase
    end
`else
    always_comb begin
        disp_next = result_next;
    end
`endif

    // Phase register, sum register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ENTER_A;
            result_reg       <= '0;
            sum_result_reg   <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            result_reg       <= result_next;
            sum_result_reg   <= disp_next;
            result_valid_reg <= (state_next == SHOW);
        end
    end

    assign bus.sum_result   = sum_result_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.phase        = state_reg;

endmodule

// File: tb/tb_keypad_sum_controller.sv
// Self-checking bench for keypad_sum_controller with a behavioural model of
// the calculator (plain integers, one update per key press). Honours
// KEYPAD_ENTRY_ECHO_EN for the expected display value.
module tb_keypad_sum_controller;

    localparam int DW  = 14;
    localparam int MAXD = 3;
`ifdef KEYPAD_ENTRY_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_sum_if #(.DATA_W(DW)) bus ();

    keypad_sum_controller #(
        .MAX_DIGITS (MAXD),
        .DATA_W     (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Calculator model: phase 0 = typing A, 1 = typing B, 2 = showing sum.
    int m_state, m_a, m_b, m_ca, m_cb, m_res;

    function automatic void model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_res = 0;
    endfunction

    function automatic void model_key(input int k);
        if (k == 12) begin
            model_reset();
        end else if (m_state == 0) begin
            if (k <= 9) begin
                if (m_ca < MAXD) begin m_a = m_a * 10 + k; m_ca++; end
            end else if (k == 10) begin
                m_b = 0; m_cb = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (k <= 9) begin
                if (m_cb < MAXD) begin m_b = m_b * 10 + k; m_cb++; end
            end else if (k == 11) begin
                m_res = m_a + m_b; m_state = 2;
            end
        end else begin
            if (k <= 9) begin
                m_a = k; m_ca = 1; m_b = 0; m_cb = 0; m_state = 0;
            end
        end
    endfunction

    function automatic logic [DW-1:0] exp_sum();
        if (!ECHO) return DW'(m_res);
        if (m_state == 0) return DW'(m_a);
        if (m_state == 1) return DW'(m_b);
        return DW'(m_res);
    endfunction

    // One key pulse; returns 1 time unit after the capturing edge.
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(posedge clk);
        model_key(int'(code));
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'($urandom);
        $display("key %h -> phase=%0d sum=%0d valid=%0b", code, bus.phase, bus.sum_result, bus.result_valid);
    endtask

    // One idle cycle with a junk code on the bus.
    task automatic idle();
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        total++; if (bus.sum_result !== DW'(0)) begin bad++; $display("FAIL reset_sum got=%0d want=0", bus.sum_result); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.result_valid); end
        total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", bus.phase); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_sum();
        logic [3:0] keys [7] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'hB};
        for (int i = 0; i < 7; i++) begin
            press(keys[i]);
            total++; if (bus.sum_result !== exp_sum()) begin bad++; $display("FAIL basic_step%0d got=%0d want=%0d", i, bus.sum_result, exp_sum()); end
        end
        total++; if (bus.sum_result !== DW'(168)) begin bad++; $display("FAIL basic_sum got=%0d want=168", bus.sum_result); end
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.result_valid); end
        total++; if (bus.phase !== 2'd2) begin bad++; $display("FAIL basic_phase got=%0d want=2", bus.phase); end
    endtask

    task automatic test_saturation();
        logic [3:0] keys [11] = '{4'hC, 4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'h9, 4'h9, 4'h9, 4'h9, 4'hB};
        for (int i = 0; i < 11; i++) begin
            press(keys[i]);
            total++; if (bus.sum_result !== exp_sum()) begin bad++; $display("FAIL sat_step%0d got=%0d want=%0d", i, bus.sum_result, exp_sum()); end
        end
        total++; if (bus.sum_result !== DW'(1998)) begin bad++; $display("FAIL sat_sum got=%0d want=1998", bus.sum_result); end
    endtask

    task automatic test_echo();
        press(4'hC);
        press(4'h4);
        total++; if (bus.sum_result !== (ECHO ? DW'(4) : DW'(0))) begin bad++; $display("FAIL echo_first got=%0d want=%0d", bus.sum_result, ECHO ? 4 : 0); end
        press(4'h7);
        total++; if (bus.sum_result !== (ECHO ? DW'(47) : DW'(0))) begin bad++; $display("FAIL echo_second got=%0d want=%0d", bus.sum_result, ECHO ? 47 : 0); end
    endtask

    task automatic test_ignored();
        logic [3:0] keys [10] = '{4'hC, 4'h3, 4'hB, 4'hE, 4'hA, 4'h6, 4'hA, 4'hE, 4'hB, 4'hE};
        for (int i = 0; i < 10; i++) begin
            press(keys[i]);
            total++; if (bus.phase !== 2'(m_state)) begin bad++; $display("FAIL ign_phase%0d got=%0d want=%0d", i, bus.phase, m_state); end
            total++; if (bus.sum_result !== exp_sum()) begin bad++; $display("FAIL ign_sum%0d got=%0d want=%0d", i, bus.sum_result, exp_sum()); end
        end
        // Ended in SHOW with 3+6; '+' and '=' must leave it alone.
        press(4'hA);
        press(4'hB);
        total++; if (bus.sum_result !== DW'(9) || bus.phase !== 2'd2) begin bad++; $display("FAIL ign_show got=%0d/%0d want=9/2", bus.sum_result, bus.phase); end
    endtask

    task automatic test_restart_clear();
        logic [3:0] keys [8] = '{4'hC, 4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'hB};
        for (int i = 0; i < 8; i++) press(keys[i]);
        total++; if (bus.sum_result !== DW'(168)) begin bad++; $display("FAIL restart_pre got=%0d want=168", bus.sum_result); end
        press(4'h5);
        total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL restart_phase got=%0d want=0", bus.phase); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL restart_valid got=%b want=0", bus.result_valid); end
        total++; if (dut.u_op_a.value_reg !== DW'(5)) begin bad++; $display("FAIL restart_op_a got=%0d want=5", dut.u_op_a.value_reg); end
        total++; if (bus.sum_result !== exp_sum()) begin bad++; $display("FAIL restart_sum got=%0d want=%0d", bus.sum_result, exp_sum()); end
        press(4'hC);
        total++; if (bus.sum_result !== DW'(0)) begin bad++; $display("FAIL clear_sum got=%0d want=0", bus.sum_result); end
        total++; if (dut.u_op_a.value_reg !== DW'(0) || dut.u_op_b.value_reg !== DW'(0)) begin bad++; $display("FAIL clear_ops got=%0d/%0d want=0/0", dut.u_op_a.value_reg, dut.u_op_b.value_reg); end
        total++; if (dut.result_reg !== DW'(0)) begin bad++; $display("FAIL clear_result got=%0d want=0", dut.result_reg); end
    endtask

    task automatic test_async_reset_back_to_back();
        press(4'h8);
        press(4'hA);
        press(4'h2);
        // Mid-cycle: outputs must clear before the next rising edge.
        #2 reset = 1'b1;
        #1;
        model_reset();
        total++; if (bus.phase !== 2'd0) begin bad++; $display("FAIL areset_phase got=%0d want=0", bus.phase); end
        total++; if (bus.sum_result !== DW'(0)) begin bad++; $display("FAIL areset_sum got=%0d want=0", bus.sum_result); end
        total++; if (dut.u_op_b.value_reg !== DW'(0)) begin bad++; $display("FAIL areset_op_b got=%0d want=0", dut.u_op_b.value_reg); end
        @(negedge clk);
        reset = 1'b0;
        press(4'h2);
        press(4'hA);
        press(4'h3);
        press(4'hB);
        total++; if (bus.sum_result !== DW'(5)) begin bad++; $display("FAIL b2b_sum got=%0d want=5", bus.sum_result); end
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", bus.result_valid); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      press(4'($urandom_range(0, 9)));
            else if (r < 68) press(4'hA);
            else if (r < 82) press(4'hB);
            else if (r < 86) press(4'hC);
            else if (r < 93) press(4'($urandom_range(13, 15)));
            else             idle();
            total++;
            if (bus.sum_result !== exp_sum() || bus.result_valid !== (m_state == 2) || bus.phase !== 2'(m_state)) begin
                bad++;
                $display("FAIL rand%0d got=%0d/%b/%0d want=%0d/%b/%0d", i, bus.sum_result, bus.result_valid, bus.phase,
                         exp_sum(), (m_state == 2), m_state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_saturation();
        test_echo();
        test_ignored();
        test_restart_clear();
        test_async_reset_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_sum_controller.md
# keypad_sum_controller

Collects two decimal operands typed on the keypad, adds them, and drives the 14-bit value shown by the 4-digit seven-segment display multiplexer. It sits directly upstream of the display multiplexer: its `sum_result` output connects straight to that block's `sum_result` input. It consumes one-cycle key pulses from the keypad scanner/debouncer.

## Interface
- `MAX_DIGITS`, default 3: maximum decimal digits per operand. Legal range is 1–3, so that the largest sum, 2·(10^MAX_DIGITS − 1) = 1998, fits the 4-digit display.
- `DATA_W`, default 14: width of the result and operand registers (covers 0–9999).
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `key_valid`, input, 1: single-cycle pulse; `key_code` is valid in that cycle.
- `key_code`, input, 4: key value, decoded as follows.
  - 0–9: digit.
  - 4'hA: '+'.
  - 4'hB: '='.
  - 4'hC: clear.
  - 4'hD–4'hF: ignored.
- `sum_result`, output, DATA_W: binary value to display.
- `result_valid`, output, 1: high while a computed sum is shown.
- `phase`, output, 2: current state encoding.
  - 0: ENTER_A.
  - 1: ENTER_B.
  - 2: SHOW.

## Operation
- **Registers:**
  - `op_a` and `op_b`, each DATA_W bits.
  - `cnt_a` and `cnt_b`, digit counters, each 0..MAX_DIGITS.
  - `result`, DATA_W bits.
  - State register.
- **ENTER_A:**
  - Digit d with `cnt_a` < MAX_DIGITS: `op_a` ← `op_a`·10 + d and `cnt_a`++.
  - Digit when `cnt_a` = MAX_DIGITS: ignored.
  - '+': go to ENTER_B, with `op_b` = 0 and `cnt_b` = 0. This applies even when `cnt_a` = 0, in which case the operand is 0.
  - '=': ignored.
- **ENTER_B:**
  - Digit: same accumulation rule applied to `op_b`/`cnt_b`.
  - '+': ignored.
  - '=': `result` ← `op_a` + `op_b` (unsigned, no overflow possible within the legal MAX_DIGITS range), then go to SHOW.
- **SHOW:**
  - Digit d: `op_a` ← d, `cnt_a` ← 1, `op_b` ← 0, `cnt_b` ← 0, go to ENTER_A. The new digit starts a fresh calculation.
  - '+' and '=': ignored.
- **Clear (4'hC), in any state:**
  - `op_a`, `op_b`, `cnt_a`, `cnt_b` and `result` are all set to 0.
  - Go to ENTER_A.
  - Clear behaves identically to reset, apart from timing: reset is asynchronous, clear takes effect on the clock edge.
- **Other inputs:**
  - Codes D–F cause no state or register change.
  - `key_code` is ignored when `key_valid` = 0.
- **Upstream contract:** `key_valid` held high for N cycles counts as N key presses. The upstream block guarantees single-cycle pulses.
- **`result_valid`:** equals 1 exactly when the state is SHOW.

## Timing
- **Reset values:**
  - State ENTER_A.
  - All registers 0.
  - `sum_result` = 0, `result_valid` = 0, `phase` = 0.
- **Output registers:** all outputs are registered. Each takes its new value on the first rising edge after the cycle in which `key_valid` is high (one-cycle latency).
- **Back-to-back keys:** pulses on consecutive cycles are each processed. No key is dropped.
- **Reset mid-entry:** forces reset values immediately, without waiting for a clock edge. The first key after reset release is processed normally.

## Configuration
- **Macro:** `KEYPAD_ENTRY_ECHO_EN`.
- **Defined:**
  - In ENTER_A, `sum_result` = `op_a`.
  - In ENTER_B, `sum_result` = `op_b`.
  - In SHOW, `sum_result` = `result`.
  - The display therefore echoes typing.
- **Undefined:**
  - `sum_result` always equals `result`, i.e. the last sum, or 0 after reset or clear.
  - Typed digits are not shown.
- State machine and `result_valid` behaviour are identical in both builds.

## Structure
- **Shared package `keypad_sum_pkg`:**
  - Key code constants: `KEY_ADD` = 4'hA, `KEY_EQ` = 4'hB, `KEY_CLR` = 4'hC.
  - Enum `sum_phase_t` {ENTER_A, ENTER_B, SHOW}.
  - Constant `DISP_W` = 14.
- **Sub-module `decimal_operand_reg`:**
  - Instantiated twice.
  - Contains the operand register and digit counter.
  - Control inputs: clear, load_digit, digit.
  - Applies the ×10+d rule and the MAX_DIGITS saturation.
- **Top level:** the state machine, the adder, and the output mux.

## Test plan
- **Basic sum:** keys 1,2,3,+,4,5,= → after '=' plus 1 cycle, `sum_result` = 168, `result_valid` = 1, `phase` = 2.
- **Digit saturation:** keys 9,9,9,9,+,9,9,9,9,= → `sum_result` = 1998; the 4th digit of each operand is ignored.
- **Echo (macro defined):** keys 4,7 → `sum_result` = 4 then 47 on successive updates. Without the macro, `sum_result` stays 0.
- **Ignored keys:** '=' in ENTER_A, '+' in ENTER_B, and 4'hE in any state → no change to `phase` or `sum_result`.
- **Restart and clear:**
  - In SHOW (result 168), key 5 → `phase` = 0, `result_valid` = 0, `op_a` = 5.
  - Then key 4'hC → all registers 0.
- **Asynchronous reset and back-to-back keys:**
  - Assert `reset` mid-cycle during ENTER_B → outputs reach reset values before the next edge.
  - After release, 3 consecutive-cycle pulses 2,+,3 followed by = → `sum_result` = 5.
